regfile: RTL and testbench

Multi-ported register file that is the read side of the CPU's architectural register state. It holds `NREGS` registers of `WIDTH` bits. It takes one write per cycle from the writeback stage and serves two independent read ports to the decode/operand-fetch stage. The highest-numbered register is hardwired to zero (XZR).

---
 rtl/regfile.sv | 57 +++++
 tb/tb_regfile.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Two-read, one-write architectural register file; the top index reads as zero (XZR).
// Optional same-cycle write-to-read forwarding is built in when REGFILE_BYPASS_EN is defined.
module regfile #(
  parameter  int WIDTH  = 64,
  parameter  int NREGS  = 32,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [WIDTH-1:0]  rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdDataB
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(NREGS - 1);

  // Only indices 0..NREGS-2 have storage; ZR is synthesised as a constant.
  logic [WIDTH-1:0] regs [NREGS-1];

  logic wr_live;
  assign wr_live = reset && wrEn && (wrAddr != ZR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wrAddr] <= wrData;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    if (a == ZR) begin
      v = '0;
    end else begin
      v = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (wrAddr == a)) begin
        v = wrData;
      end
`endif
    end
    return v;
  endfunction

  always_comb begin
    rdDataA = read_port(rdAddrA);
    rdDataB = read_port(rdAddrB);
  end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: array-based reference model checked every cycle on both read ports,
// plus literal checks of the directed scenarios and a randomized phase.
module tb_regfile;

  localparam logic [63:0] PAT = 64'h0101_0101_0101_0101;
  localparam logic [63:0] C1  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C2  = 64'hFFFF_0000_FFFF_0000;

  logic        clk;
  logic        reset;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic [4:0]  rdAddrA;
  logic [63:0] rdDataA;
  logic [4:0]  rdAddrB;
  logic [63:0] rdDataB;

  regfile dut (
    .clk     (clk),
    .reset   (reset),
    .wrEn    (wrEn),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .rdAddrA (rdAddrA),
    .rdDataA (rdDataA),
    .rdAddrB (rdAddrB),
    .rdDataB (rdDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  logic [63:0] model [32];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural state as the spec defines it: reset wins, ZR writes vanish.
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 32; i++) model[i] <= 64'd0;
    end else if (wrEn === 1'b1 && wrAddr != 5'd31) begin
      model[wrAddr] <= wrData;
    end
  end

  function automatic logic [63:0] expect_rd(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wrEn && reset && wrAddr == a) return wrData;
`endif
    return model[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("modelA", rdDataA, expect_rd(rdAddrA));
      check("modelB", rdDataB, expect_rd(rdAddrB));
    end
  end

  task automatic drive(input logic rst, input logic en, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    reset   = rst;
    wrEn    = en;
    wrAddr  = wa;
    wrData  = wd;
    rdAddrA = ra;
    rdAddrB = rb;
  endtask

  initial begin
    reset = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0;

    // Reset then sweep both ports.
    drive(1'b0, 1'b1, 5'd4, 64'h1234, 5'd0, 5'd0);
    chk_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      #2;
      check("rst_sweepA", rdDataA, 64'd0);
      check("rst_sweepB", rdDataB, 64'd0);
    end

    // Basic writes and dual reads.
    drive(1'b1, 1'b1, 5'd5, C1, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd6, C2, 5'd5, 5'd6);
    #2 check("x5_after_write", rdDataA, C1);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
    #2 check("x5_portA", rdDataA, C1);
    check("x6_portB", rdDataB, C2);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    #2 check("same_addrA", rdDataA, C1);
    check("same_addrB", rdDataB, C1);

    // ZR discard and wrEn=0 hold.
    drive(1'b1, 1'b1, 5'd31, 64'hDEAD_BEEF, 5'd31, 5'd31);
    #2 check("zr_inflightA", rdDataA, 64'd0);
    check("zr_inflightB", rdDataB, 64'd0);
    drive(1'b1, 1'b0, 5'd5, 64'h1, 5'd31, 5'd5);
    #2 check("zr_after", rdDataA, 64'd0);
    check("x5_intact", rdDataB, C1);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
    #2 check("x5_hold", rdDataA, C1);
    check("x6_hold", rdDataB, C2);

    // Same-cycle read/write of X7.
    drive(1'b1, 1'b1, 5'd7, 64'hA, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd7, 64'hB, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    #2 check("x7_pre_edge", rdDataA, 64'hB);
`else
    #2 check("x7_pre_edge", rdDataA, 64'hA);
`endif
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
    #2 check("x7_post_edge", rdDataA, 64'hB);

    // Reset priority over a write, then first post-reset write.
    drive(1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd3);
    drive(1'b0, 1'b1, 5'd3, 64'h77, 5'd3, 5'd3);
    #2 check("x3_in_reset_cycle", rdDataA, 64'h55);
    drive(1'b1, 1'b1, 5'd3, 64'h99, 5'd3, 5'd5);
`ifdef REGFILE_BYPASS_EN
    #2 check("x3_cleared", rdDataA, 64'h99);
`else
    #2 check("x3_cleared", rdDataA, 64'd0);
`endif
    check("x5_cleared", rdDataB, 64'd0);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    #2 check("x3_after_reset_write", rdDataA, 64'h99);

    // Full sweep write then read A ascending, B descending.
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b1, 5'(i), 64'(i) * PAT, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      #2;
      check("sweepA", rdDataA, (i == 31) ? 64'd0 : 64'(i) * PAT);
      check("sweepB", rdDataB, (i == 0) ? 64'd0 : 64'(31 - i) * PAT);
    end

    // Randomized traffic, occasional reset, addresses biased to collide.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
    end

    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    @(posedge clk);
    #6;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
